lsu_stage: RTL and testbench

Load/store stage for the 64-bit RISC-V core. It sits directly downstream of the execute datapath. It consumes the effective address (ALU result), the store data (register read port 2), the MemRead/MemWrite controls and funct3. It performs a byte-addressed little-endian access to an internal data memory with a fixed multi-cycle latency, and stalls the core until the access completes. It returns sign- or zero-extended load data, flags illegal accesses, and exposes the memory array for debug.

---
 rtl/lsu_stage_if.sv | 25 ++
 rtl/lsu_stage.sv | 151 +++++++++++++++
 tb/tb_lsu_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_stage_if.sv
// Load/store stage bus: request from the core, response and debug view back.
interface lsu_stage_if #(
  parameter int unsigned DEPTH = 512
);
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [63:0]           addr;
  logic [63:0]           wdata;
  logic [63:0]           rdata;
  logic                  done;
  logic                  stall;
  logic                  err;
  logic [DEPTH-1:0][7:0] mem;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, done, stall, err, mem
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, done, stall, err, mem
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: fixed-latency little-endian access to an internal byte
// memory with legality checking, sign/zero extension and core stall.
module lsu_stage #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  lsu_stage_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  illegal;
  logic                  accept;
  logic                  finish;

  logic [ADDR_W-1:0]     addr_q;
  logic [63:0]           wdata_q;
  logic [2:0]            f3_q;
  logic                  write_q;
  logic [63:0]           rdata_q;
  logic [DEPTH-1:0][7:0] mem_q;
  logic [63:0]           raw;
  logic [63:0]           ext;
  logic [3:0]            nbytes;

  // Request legality, evaluated on the live inputs
  always_comb begin
    req = bus.mem_read | bus.mem_write;
    unique case (bus.funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = |bus.addr[1:0];
      default: misaligned = |bus.addr[2:0];
    endcase
    out_of_range = |bus.addr[63:ADDR_W];
    illegal = req & ((bus.mem_read & bus.mem_write) |
                     (bus.funct3 == 3'b111) |
                     (bus.mem_write & bus.funct3[2]) |
                     misaligned | out_of_range);
  end

  // Next-state logic; requests are only sampled in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !illegal) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Little-endian gather of the eight bytes starting at the latched address
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem_q[ADDR_W'(addr_q + ADDR_W'(i))];
    end
  end

  always_comb begin
    unique case (f3_q)
      3'b000:  ext = {{56{raw[7]}},  raw[7:0]};
      3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
      3'b100:  ext = {56'd0, raw[7:0]};
      3'b101:  ext = {48'd0, raw[15:0]};
      3'b110:  ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

  assign nbytes = 4'(1) << f3_q[1:0];

  // Request latch, store commit and load result; reset wins over a pending commit
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      mem_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr[ADDR_W-1:0];
        wdata_q <= bus.wdata;
        f3_q    <= bus.funct3;
        write_q <= bus.mem_write;
      end
      if (finish) begin
        if (write_q) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
              mem_q[ADDR_W'(addr_q + ADDR_W'(i))] <= wdata_q[8*i +: 8];
            end
          end
        end else begin
          rdata_q <= ext;
        end
      end
    end
  end

  assign bus.stall = ~reset & (accept | (state_q == BUSY));
  assign bus.err   = ~reset & (state_q == IDLE) & illegal;
  assign bus.done  = ~reset & (state_q == DONE);
  assign bus.rdata = rdata_q;
  assign bus.mem   = mem_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized and directed bench for lsu_stage against a byte-array reference model.
module tb_lsu_stage;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned MEM_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_stage_if #(.DEPTH(DEPTH)) bus();

  lsu_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  model_mem [DEPTH];
  logic [63:0] exp_rdata;
  bit          exp_stall, exp_err, exp_done;
  int          n_cmp, n_bad;
  int          done_cnt, stall_cnt;
  logic [63:0] s_rdata;
  logic        s_stall, s_err, s_done;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [63:0] a);
    int sz;
    if (!(rd || wr)) return 1'b0;
    sz = 1 << f3[1:0];
    return (rd && wr) || (f3 == 3'd7) || (wr && f3 >= 3'd4) ||
           ((a % 64'(sz)) != 0) || (a >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    int sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    v  = '0;
    for (int i = 0; i < sz; i++) v = v | (64'(model_mem[a + 64'(i)]) << (8 * i));
    if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
    return v;
  endfunction

  // Sample and check every output on the falling edge, then move to just after the next rise
  task automatic tick();
    int bad;
    @(negedge clk);
    s_rdata = bus.rdata;
    s_stall = bus.stall;
    s_err   = bus.err;
    s_done  = bus.done;
    done_cnt  += int'(s_done);
    stall_cnt += int'(s_stall);
    cmp("stall", 64'(s_stall), 64'(exp_stall));
    cmp("err",   64'(s_err),   64'(exp_err));
    cmp("done",  64'(s_done),  64'(exp_done));
    cmp("rdata", s_rdata, exp_rdata);
    bad = -1;
    for (int i = 0; i < int'(DEPTH); i++)
      if (bad < 0 && bus.mem[i] !== model_mem[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL mem[%0d]: got %h expected %h at %0t", bad, bus.mem[bad], model_mem[bad], $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    exp_stall = 1'b0;
    exp_err   = 1'b0;
    exp_done  = 1'b0;
    tick();
  endtask

  // One request as the core sees it: stall for MEM_LAT+1 cycles then a DONE cycle
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input bit hold);
    bit ill;
    int sz;
    ill = is_illegal(rd, wr, f3, a);
    sz  = 1 << f3[1:0];
    set_req(rd, wr, f3, a, wd);
    exp_done  = 1'b0;
    exp_err   = ill;
    exp_stall = !ill && (rd || wr);
    tick();
    if (!(rd || wr) || ill) return;
    for (int c = 1; c <= int'(MEM_LAT); c++) begin
      bus.addr   = {$urandom, $urandom};
      bus.wdata  = {$urandom, $urandom};
      bus.funct3 = 3'($urandom);
      exp_stall  = 1'b1;
      exp_err    = 1'b0;
      tick();
    end
    if (hold) set_req(rd, wr, f3, a, wd);
    else      set_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    exp_stall = 1'b0;
    exp_err   = 1'b0;
    exp_done  = 1'b1;
    if (wr) for (int i = 0; i < sz; i++) model_mem[a + 64'(i)] = wd[8*i +: 8];
    else    exp_rdata = model_load(f3, a);
    tick();
    exp_done = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
    exp_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bit rd, wr, hold;
    int r, sz;
    logic [2:0]  f3;
    logic [63:0] a;

    n_cmp = 0; n_bad = 0; done_cnt = 0; stall_cnt = 0;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    clear_model();
    exp_stall = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
    tick();
    reset = 1'b0;
    idle();
    cmp("reset_rdata", s_rdata, 64'd0);

    // Store/load round trip
    stall_cnt = 0; done_cnt = 0;
    access(1'b0, 1'b1, 3'b011, 64'h010, 64'h1122334455667788, 1'b0);
    cmp("sd_stall_cycles", 64'(stall_cnt), 64'(MEM_LAT + 1));
    cmp("sd_done_pulses",  64'(done_cnt), 64'd1);
    access(1'b1, 1'b0, 3'b011, 64'h010, 64'd0, 1'b0);
    cmp("ld_rdata", s_rdata, 64'h1122334455667788);
    cmp("mem_010", 64'(bus.mem[16]), 64'h88);
    cmp("mem_017", 64'(bus.mem[23]), 64'h11);

    // Sign versus zero extension
    access(1'b0, 1'b1, 3'b000, 64'h005, 64'hDEAD_BEEF_0000_0080, 1'b0);
    access(1'b1, 1'b0, 3'b000, 64'h005, 64'd0, 1'b0);
    cmp("lb_sext", s_rdata, 64'hFFFFFFFFFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 64'h005, 64'd0, 1'b0);
    cmp("lbu_zext", s_rdata, 64'h80);
    access(1'b1, 1'b0, 3'b101, 64'h004, 64'd0, 1'b0);
    cmp("lhu_zext", s_rdata, 64'h8000);
    cmp("mem_004", 64'(bus.mem[4]), 64'h00);

    // Partial store preservation
    access(1'b0, 1'b1, 3'b011, 64'h020, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    access(1'b0, 1'b1, 3'b001, 64'h022, 64'h0000000000001234, 1'b0);
    access(1'b1, 1'b0, 3'b011, 64'h020, 64'd0, 1'b0);
    cmp("sh_merge", s_rdata, 64'hFFFFFFFF1234FFFF);

    // Illegal requests
    access(1'b1, 1'b0, 3'b010, 64'h002, 64'd0, 1'b0);
    cmp("ill_lw_err", 64'(s_err), 64'd1);
    cmp("ill_lw_stall", 64'(s_stall), 64'd0);
    access(1'b0, 1'b1, 3'b011, 64'h200, 64'h0123456789ABCDEF, 1'b0);
    cmp("ill_sd_err", 64'(s_err), 64'd1);
    access(1'b1, 1'b1, 3'b011, 64'h040, 64'h55, 1'b0);
    cmp("ill_rw_err", 64'(s_err), 64'd1);
    access(1'b1, 1'b0, 3'b111, 64'h040, 64'd0, 1'b0);
    cmp("ill_f3_err", 64'(s_err), 64'd1);
    idle();
    cmp("ill_no_done", 64'(s_done), 64'd0);
    cmp("ill_rdata_kept", s_rdata, 64'hFFFFFFFF1234FFFF);

    // Reset during the second BUSY cycle aborts the store
    set_req(1'b0, 1'b1, 3'b011, 64'h030, 64'hAA);
    exp_stall = 1'b1; exp_err = 1'b0; exp_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_stall = 1'b0;
    tick();
    reset = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    clear_model();
    tick();
    cmp("rst_mem_030", 64'(bus.mem[48]), 64'h00);
    cmp("rst_rdata", s_rdata, 64'd0);
    cmp("rst_stall", 64'(s_stall), 64'd0);

    // Held request through DONE, then an immediate new request
    access(1'b0, 1'b1, 3'b010, 64'h040, 64'h00000000CAFEF00D, 1'b0);
    done_cnt = 0; stall_cnt = 0;
    access(1'b1, 1'b0, 3'b010, 64'h040, 64'd0, 1'b1);
    cmp("b2b_one_done", 64'(done_cnt), 64'd1);
    cmp("lw_sext", s_rdata, 64'hFFFFFFFFCAFEF00D);
    access(1'b1, 1'b0, 3'b110, 64'h040, 64'd0, 1'b0);
    cmp("b2b_two_done", 64'(done_cnt), 64'd2);
    cmp("b2b_stall_cycles", 64'(stall_cnt), 64'(2 * (MEM_LAT + 1)));
    cmp("lwu_zext", s_rdata, 64'h00000000CAFEF00D);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      r  = int'($urandom_range(0, 19));
      rd = (r < 8) || (r == 16);
      wr = (r >= 8 && r < 16) || (r == 16);
      if (r == 17) f3 = 3'($urandom);
      else if (wr) f3 = 3'($urandom_range(0, 3));
      else f3 = 3'($urandom_range(0, 6));
      sz = 1 << f3[1:0];
      a  = 64'($urandom_range(0, 127)) & ~64'(sz - 1);
      if (r == 18) a = a | 64'd1;
      if (r == 19) a = a + (($urandom_range(0, 1) == 0) ? 64'(DEPTH) : (64'd1 << 40));
      hold = ($urandom_range(0, 3) == 0);
      if (r == 17 && $urandom_range(0, 1) == 0) begin
        rd = 1'b0; wr = 1'b0;
      end
      access(rd, wr, f3, a, {$urandom, $urandom}, hold);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
